// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer
//
// Walks a synchronous configuration ROM of packed {register, value} entries and issues one SCCB
// write per entry through a request/done handshake. In-band markers insert delays or end the
// table early; NACKed writes are retried up to MAX_RETRY extra times before the pass aborts.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               single-cycle pulse, begins a pass (ignored while busy)
//   rom_addr / rom_data ROM address out, entry in (valid one cycle after rom_addr)
//   sccb_req/reg/dat    write request and its payload, held stable until accepted
//   sccb_ready          master accepts when sccb_req && sccb_ready
//   sccb_done/nack      completion pulse; nack qualifies done
//   busy                pass in progress
//   done / error        sticky result of the last pass
//   err_addr            ROM address of the entry whose write exhausted its retries
module ov7670_config_sequencer #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned REG_W        = 8,
    parameter int unsigned DAT_W        = 8,
    parameter int unsigned DELAY_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [REG_W+DAT_W-1:0] END_MARK   = '1,
    parameter logic [REG_W+DAT_W-1:0] DELAY_MARK = {{REG_W{1'b1}}, DAT_W'(8'hF0)}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [REG_W+DAT_W-1:0]  rom_data,
    output logic                    sccb_req,
    output logic [REG_W-1:0]        sccb_reg,
    output logic [DAT_W-1:0]        sccb_dat,
    input  logic                    sccb_ready,
    input  logic                    sccb_done,
    input  logic                    sccb_nack,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_W-1:0]       err_addr
);

    localparam int unsigned DelayW = $clog2(DELAY_CYCLES + 1);
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DelayW-1:0] DelayLoad = DelayW'(DELAY_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);
    localparam logic [ADDR_W-1:0] AddrMax   = '1;

    typedef enum logic [3:0] {
        StIdle,
        StWaitRom,
        StDecode,
        StWrite,
        StWaitAck,
        StDelay,
        StNext,
        StDone,
        StError
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [RetryW-1:0]    retry_q, retry_d;
    logic [DelayW-1:0]    delay_q, delay_d;
    logic                 req_q, req_d;
    logic [REG_W-1:0]     reg_q, reg_d;
    logic [DAT_W-1:0]     dat_q, dat_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [ADDR_W-1:0]    err_addr_q, err_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            retry_q    <= '0;
            delay_q    <= '0;
            req_q      <= 1'b0;
            reg_q      <= '0;
            dat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            retry_q    <= retry_d;
            delay_q    <= delay_d;
            req_q      <= req_d;
            reg_q      <= reg_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        retry_d    = retry_q;
        delay_d    = delay_q;
        req_d      = req_q;
        reg_d      = reg_q;
        dat_d      = dat_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    rom_addr_d = '0;
                    retry_d    = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StWaitRom;
                end
            end
            // rom_addr was updated on the edge entering this state; data lands next cycle.
            StWaitRom: state_d = StDecode;
            StDecode: begin
                if (rom_data == END_MARK) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (rom_data == DELAY_MARK) begin
                    delay_d = DelayLoad;
                    state_d = StDelay;
                end else begin
                    reg_d   = rom_data[REG_W+DAT_W-1:DAT_W];
                    dat_d   = rom_data[DAT_W-1:0];
                    req_d   = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (sccb_ready) begin
                    req_d   = 1'b0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (sccb_done) begin
                    if (!sccb_nack) begin
                        state_d = StNext;
                    end else if (retry_q < RetryMax) begin
                        // reg/dat are still held, so the retry resends the same write.
                        retry_d = retry_q + 1'b1;
                        req_d   = 1'b1;
                        state_d = StWrite;
                    end else begin
                        err_addr_d = rom_addr_q;
                        busy_d     = 1'b0;
                        error_d    = 1'b1;
                        state_d    = StError;
                    end
                end
            end
            StDelay: begin
                if (delay_q == '0) begin
                    state_d = StNext;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            StNext: begin
                // The last ROM slot is an implicit end of table; the address never wraps.
                if (rom_addr_q == AddrMax) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    retry_d    = '0;
                    state_d    = StWaitRom;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rom_addr = rom_addr_q;
    assign sccb_req = req_q;
    assign sccb_reg = reg_q;
    assign sccb_dat = dat_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
module tb_ov7670_config_sequencer;

    localparam int unsigned AW = 3;
    localparam int unsigned DC = 16;
    localparam int unsigned MR = 3;
    localparam int unsigned NE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        sccb_req;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_dat;
    logic        sccb_ready;
    logic        sccb_done;
    logic        sccb_nack;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_addr;

    always #5 clk = ~clk;

    ov7670_config_sequencer #(
        .ADDR_W(AW), .REG_W(8), .DAT_W(8), .DELAY_CYCLES(DC), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_req(sccb_req), .sccb_reg(sccb_reg), .sccb_dat(sccb_dat),
        .sccb_ready(sccb_ready), .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .busy(busy), .done(done), .error(error), .err_addr(err_addr)
    );

    // Synchronous configuration ROM
    logic [15:0] rom [NE];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          nack_cnt [NE];
    int          att [NE];
    logic [18:0] obs_q [$];
    logic [18:0] exp_q [$];
    int          obs_t [$];
    bit          m_fixed;
    int          m_lat_min, m_lat_max;
    bit          m_busy;
    int          m_wait;
    bit          m_nack;
    int          n_chk = 0;
    int          n_pass = 0;

    // expected pass results
    bit          exp_done, exp_err;
    logic [2:0]  exp_end_addr;
    logic [2:0]  mdl_err_addr = '0;
    // snapshot right after start
    logic [2:0]  s_addr;
    logic        s_done, s_busy;

    // SCCB master: decides ready at each negedge; a request seen with ready high is accepted at
    // the following posedge. Slave answers NACK for the first nack_cnt[addr] attempts.
    initial begin
        sccb_ready = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0;
        m_busy = 1'b0; m_wait = 0; m_nack = 1'b0;
        forever begin
            @(negedge clk);
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
            if (!rst_n) begin
                sccb_ready = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy) begin
                sccb_ready = 1'b0;
                if (m_wait == 0) begin
                    sccb_done = 1'b1;
                    sccb_nack = m_nack;
                    m_busy = 1'b0;
                end else begin
                    m_wait--;
                end
            end else begin
                sccb_ready = m_fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (sccb_req && sccb_ready) begin
                    obs_q.push_back({rom_addr, sccb_reg, sccb_dat});
                    obs_t.push_back(cyc);
                    m_nack = (att[rom_addr] < nack_cnt[rom_addr]);
                    att[rom_addr]++;
                    m_wait = $urandom_range(m_lat_min, m_lat_max);
                    m_busy = 1'b1;
                end
            end
        end
    end

    function automatic logic [15:0] rand_entry();
        logic [7:0] r;
        r = 8'($urandom_range(0, 254));
        return {r, 8'($urandom)};
    endfunction

    // Reference: one pass over the table as a plain loop over ROM slots.
    task automatic model_pass();
        int tries;
        exp_q.delete();
        exp_done = 1'b1;
        exp_err = 1'b0;
        exp_end_addr = 3'(NE - 1);
        for (int a = 0; a < NE; a++) begin
            if (rom[a] == 16'hFFFF) begin
                exp_end_addr = 3'(a);
                break;
            end
            if (rom[a] == 16'hFFF0) continue;
            tries = (nack_cnt[a] > MR) ? MR + 1 : nack_cnt[a] + 1;
            for (int k = 0; k < tries; k++) exp_q.push_back({3'(a), rom[a]});
            if (nack_cnt[a] > MR) begin
                exp_done = 1'b0;
                exp_err = 1'b1;
                mdl_err_addr = 3'(a);
                exp_end_addr = 3'(a);
                break;
            end
        end
    endtask

    function automatic int first_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one pass; mid_at >= 0 pulses start again that many cycles into the pass.
    task automatic run_pass(input int mid_at, output bit to);
        int cnt;
        foreach (att[i]) att[i] = 0;
        obs_q.delete();
        obs_t.delete();
        model_pass();
        pulse_start();
        s_addr = rom_addr;
        s_done = done;
        s_busy = busy;
        cnt = 0;
        while (busy && cnt < 3000) begin
            @(negedge clk);
            start = (cnt == mid_at);
            cnt++;
        end
        start = 1'b0;
        to = busy;
    endtask

    task automatic clear_table();
        foreach (rom[i]) begin
            rom[i] = rand_entry();
            nack_cnt[i] = 0;
        end
    endtask

    task automatic check_pass(input string name, input bit to);
        int d;
        n_chk++;
        if (to !== 1'b0) $display("FAIL %s timeout: busy still %b, required 0", name, busy);
        else n_pass++;
        n_chk++;
        d = first_diff();
        if (d != -1)
            $display("FAIL %s writes: diff at %0d, got %0d writes, required %0d",
                     name, d, obs_q.size(), exp_q.size());
        else n_pass++;
        n_chk++;
        if ({done, error} !== {exp_done, exp_err})
            $display("FAIL %s done/error: got %b%b, required %b%b", name, done, error,
                     exp_done, exp_err);
        else n_pass++;
        n_chk++;
        if (rom_addr !== exp_end_addr)
            $display("FAIL %s rom_addr: got %0d, required %0d", name, rom_addr, exp_end_addr);
        else n_pass++;
        n_chk++;
        if (err_addr !== mdl_err_addr)
            $display("FAIL %s err_addr: got %0d, required %0d", name, err_addr, mdl_err_addr);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({rom_addr, sccb_req, sccb_reg, sccb_dat, busy, done, error, err_addr} !== '0)
            $display("FAIL reset_values: got %h, required 0",
                     {rom_addr, sccb_req, sccb_reg, sccb_dat, busy, done, error, err_addr});
        else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_chk++;
        if ({busy, sccb_req, done} !== 3'b000)
            $display("FAIL idle_after_reset: busy/req/done %b, required 000",
                     {busy, sccb_req, done});
        else n_pass++;
    endtask

    task automatic test_delay_table();
        bit to;
        clear_table();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214; rom[3] = 16'hFFFF;
        m_fixed = 1'b1; m_lat_min = 0; m_lat_max = 0;
        run_pass(-1, to);
        check_pass("delay_table", to);
        n_chk++;
        if (s_busy !== 1'b1) $display("FAIL busy_after_start: got %b, required 1", s_busy);
        else n_pass++;
        // acked write to next accept is 5 cycles; a delay entry adds its own 3 plus DC
        n_chk++;
        if (obs_t.size() != 2 || (obs_t[1] - obs_t[0]) != int'(DC) + 8)
            $display("FAIL delay_gap: got %0d writes gap %0d, required 2 writes gap %0d",
                     obs_t.size(), (obs_t.size() == 2) ? obs_t[1] - obs_t[0] : -1, DC + 8);
        else n_pass++;
    endtask

    task automatic test_spurious_done();
        @(negedge clk);
        #1 sccb_done = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, done, error} !== 3'b010)
            $display("FAIL spurious_done: busy/done/error %b, required 010",
                     {busy, done, error});
        else n_pass++;
    endtask

    task automatic test_retry_ok();
        bit to;
        int n5;
        clear_table();
        rom[7] = 16'hFFFF;
        nack_cnt[5] = 3;
        m_fixed = 1'b0; m_lat_min = 0; m_lat_max = 3;
        run_pass(-1, to);
        check_pass("retry_ok", to);
        n5 = 0;
        foreach (obs_q[i]) if (obs_q[i] === {3'd5, rom[5]}) n5++;
        n_chk++;
        if (n5 != 4) $display("FAIL retry_ok_count: got %0d requests for addr 5, required 4", n5);
        else n_pass++;
    endtask

    task automatic test_retry_fail();
        bit to;
        int n0;
        clear_table();
        nack_cnt[7] = 4;
        run_pass(-1, to);
        check_pass("retry_fail", to);
        n0 = obs_q.size();
        repeat (20) @(negedge clk);
        n_chk++;
        if (obs_q.size() != n0 || sccb_req !== 1'b0)
            $display("FAIL after_error: got %0d extra writes req %b, required 0 and 0",
                     obs_q.size() - n0, sccb_req);
        else n_pass++;
    endtask

    task automatic test_no_end();
        bit to;
        clear_table();
        run_pass(-1, to);
        check_pass("no_end", to);
        n_chk++;
        if (obs_q.size() != 8) $display("FAIL no_end_count: got %0d, required 8", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit to;
        clear_table();
        rom[4] = 16'hFFFF;
        run_pass(10, to);
        check_pass("start_mid_pass", to);
        run_pass(-1, to);
        n_chk++;
        if ({s_addr, s_done, s_busy} !== {3'd0, 1'b0, 1'b1})
            $display("FAIL restart_state: addr/done/busy %0d/%b/%b, required 0/0/1",
                     s_addr, s_done, s_busy);
        else n_pass++;
        check_pass("restart", to);
    endtask

    task automatic test_random();
        bit to;
        int r;
        m_fixed = 1'b0; m_lat_min = 0; m_lat_max = 4;
        for (int it = 0; it < 8; it++) begin
            foreach (rom[i]) begin
                r = $urandom_range(0, 15);
                rom[i] = (r == 0) ? 16'hFFFF : (r == 1) ? 16'hFFF0 : rand_entry();
                r = $urandom_range(0, 9);
                nack_cnt[i] = (r < 6) ? 0 : r - 5;
            end
            run_pass(-1, to);
            check_pass("random", to);
        end
    endtask

    task automatic test_reset_mid_pass();
        int cnt;
        int seen;
        clear_table();
        m_fixed = 1'b1; m_lat_min = 30; m_lat_max = 30;
        foreach (att[i]) att[i] = 0;
        obs_q.delete();
        pulse_start();
        cnt = 0;
        while (obs_q.size() == 0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        mdl_err_addr = '0;
        n_chk++;
        if ({rom_addr, sccb_req, sccb_reg, sccb_dat, busy, done, error, err_addr} !== '0 ||
            obs_q.size() != 1)
            $display("FAIL reset_mid_pass: outputs %h writes %0d, required 0 and 1",
                     {rom_addr, sccb_req, sccb_reg, sccb_dat, busy, done, error, err_addr},
                     obs_q.size());
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || sccb_req) seen++;
        end
        n_chk++;
        if (seen != 0 || obs_q.size() != 1)
            $display("FAIL quiet_after_reset: active cycles %0d writes %0d, required 0 and 1",
                     seen, obs_q.size());
        else n_pass++;
    endtask

    initial begin
        foreach (rom[i]) rom[i] = '0;
        foreach (nack_cnt[i]) nack_cnt[i] = 0;
        foreach (att[i]) att[i] = 0;
        m_fixed = 1'b1; m_lat_min = 0; m_lat_max = 0;
        test_reset();
        test_delay_table();
        test_spurious_done();
        test_retry_ok();
        test_retry_fail();
        test_no_end();
        test_start_ignored();
        test_random();
        test_reset_mid_pass();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
